// File: rtl/bpu_update_sched.sv
// Predictor-table update scheduler: clears every table index after reset, then
// queues pipe0/pipe1 training updates in order onto the single table write port.
// Define BPU_UPD_MERGE_EN to fold repeated same-pc branch updates into the youngest entry.
module bpu_update_sched #(
  parameter int DEPTH    = 8,
  parameter int IDX_BITS = 7
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                upd0_valid,
  input  logic [31:0]         upd0_pc,
  input  logic [31:0]         upd0_dest,
  input  logic [31:0]         upd0_ret,
  input  logic [4:0]          upd0_kind,
  input  logic                upd0_taken,
  input  logic                upd1_valid,
  input  logic [31:0]         upd1_pc,
  input  logic [31:0]         upd1_dest,
  input  logic [31:0]         upd1_ret,
  input  logic [4:0]          upd1_kind,
  input  logic                upd1_taken,
  output logic                upd_ready,
  input  logic                tbl_busy,
  output logic                wr_valid,
  output logic [31:0]         wr_pc,
  output logic [31:0]         wr_dest,
  output logic [31:0]         wr_ret,
  output logic [4:0]          wr_kind,
  output logic                wr_taken,
  output logic                clr_valid,
  output logic [IDX_BITS-1:0] clr_idx,
  output logic                init_done,
  output logic                overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dest;
    logic [31:0] ret;
    logic [4:0]  kind;
    logic        taken;
  } ent_t;

  state_t        state;
  ent_t          mem [DEPTH];
  logic [PW-1:0] head, tail, idx1, m1_idx;
  logic [CW-1:0] count, count_nxt, enq;
  logic          acc0, acc1, a0, a1, m0, m1, pop, run_nxt;

  assign acc0 = upd_ready && upd0_valid && (upd0_kind != '0);
  assign acc1 = upd_ready && upd1_valid && (upd1_kind != '0);

  assign wr_valid = (state == RUN) && (count != '0) && !tbl_busy;
  assign pop      = wr_valid;
  assign wr_pc    = mem[head].pc;
  assign wr_dest  = mem[head].dest;
  assign wr_ret   = mem[head].ret;
  assign wr_kind  = mem[head].kind;
  assign wr_taken = mem[head].taken;

`ifdef BPU_UPD_MERGE_EN
  localparam logic [4:0] K_BR = 5'b00001;
  logic [PW-1:0] yng_idx;
  logic          res_ok, c1_ok;
  logic [31:0]   c1_pc;

  // Youngest resident entry; off-limits if it is the head leaving this cycle.
  assign yng_idx = tail - PW'(1);
  assign res_ok  = (count != '0) && (mem[yng_idx].kind == K_BR) &&
                   !(pop && count == CW'(1));
  assign m0      = acc0 && (upd0_kind == K_BR) && res_ok && (mem[yng_idx].pc == upd0_pc);
  // Pipe1 chains onto pipe0's fresh entry when pipe0 allocated this cycle.
  assign c1_ok   = a0 ? (upd0_kind == K_BR) : res_ok;
  assign c1_pc   = a0 ? upd0_pc : mem[yng_idx].pc;
  assign m1      = acc1 && (upd1_kind == K_BR) && c1_ok && (c1_pc == upd1_pc);
  assign m1_idx  = a0 ? tail : yng_idx;
`else
  assign m0     = 1'b0;
  assign m1     = 1'b0;
  assign m1_idx = tail;
`endif

  assign a0        = acc0 && !m0;
  assign a1        = acc1 && !m1;
  assign idx1      = tail + PW'(a0);
  assign enq       = CW'(a0) + CW'(a1);
  assign count_nxt = count + enq - CW'(pop);
  assign run_nxt   = (state == RUN) || (clr_valid && clr_idx == '1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= INIT;
      clr_idx   <= '0;
      clr_valid <= 1'b0;
      init_done <= 1'b0;
      overflow  <= 1'b0;
      upd_ready <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (state == INIT) begin
        if (!clr_valid) begin
          clr_valid <= 1'b1;
        end else if (clr_idx == '1) begin
          state     <= RUN;
          clr_valid <= 1'b0;
          init_done <= 1'b1;
        end else begin
          clr_idx <= clr_idx + 1'b1;
        end
      end
      if ((upd0_valid || upd1_valid) && !upd_ready) overflow <= 1'b1;
      head      <= head + PW'(pop);
      tail      <= tail + PW'(a0) + PW'(a1);
      count     <= count_nxt;
      upd_ready <= run_nxt && (count_nxt <= DEPTH_C - CW'(2));
    end
  end

  // Payload storage; later field writes win when a merge targets a fresh slot.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (a0) mem[tail] <= '{upd0_pc, upd0_dest, upd0_ret, upd0_kind, upd0_taken};
      if (m0) begin
        mem[tail - PW'(1)].dest  <= upd0_dest;
        mem[tail - PW'(1)].taken <= upd0_taken;
      end
      if (a1) mem[idx1] <= '{upd1_pc, upd1_dest, upd1_ret, upd1_kind, upd1_taken};
      if (m1) begin
        mem[m1_idx].dest  <= upd1_dest;
        mem[m1_idx].taken <= upd1_taken;
      end
    end
  end

  a_kind0_onehot: assert property (@(posedge clk) disable iff (!resetn)
    upd0_valid |-> $onehot0(upd0_kind));
  a_kind1_onehot: assert property (@(posedge clk) disable iff (!resetn)
    upd1_valid |-> $onehot0(upd1_kind));

endmodule

// File: tb/tb_bpu_update_sched.sv
// Directed bench for bpu_update_sched: scoreboard queue of expected table writes,
// immediate-assertion checks on control outputs.
module tb_bpu_update_sched;
  localparam int DEPTH = 8;
  localparam int IDX_BITS = 7;
  localparam logic [4:0] K_BR = 5'b00001, K_J = 5'b00010, K_JAL = 5'b00100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dest;
    logic [31:0] ret;
    logic [4:0]  kind;
    logic        taken;
  } exp_t;

  logic clk = 1'b0, resetn = 1'b0, tbl_busy = 1'b0;
  logic upd0_valid = 1'b0, upd0_taken = 1'b0, upd1_valid = 1'b0, upd1_taken = 1'b0;
  logic [31:0] upd0_pc = '0, upd0_dest = '0, upd0_ret = '0;
  logic [31:0] upd1_pc = '0, upd1_dest = '0, upd1_ret = '0;
  logic [4:0]  upd0_kind = '0, upd1_kind = '0;
  logic upd_ready, wr_valid, wr_taken, clr_valid, init_done, overflow;
  logic [31:0] wr_pc, wr_dest, wr_ret;
  logic [4:0]  wr_kind;
  logic [IDX_BITS-1:0] clr_idx;

  exp_t q[$];
  int pass_cnt = 0, total = 0, fail_cnt = 0;

  bpu_update_sched #(.DEPTH(DEPTH), .IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .resetn(resetn),
    .upd0_valid(upd0_valid), .upd0_pc(upd0_pc), .upd0_dest(upd0_dest), .upd0_ret(upd0_ret),
    .upd0_kind(upd0_kind), .upd0_taken(upd0_taken),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_dest(upd1_dest), .upd1_ret(upd1_ret),
    .upd1_kind(upd1_kind), .upd1_taken(upd1_taken),
    .upd_ready(upd_ready), .tbl_busy(tbl_busy),
    .wr_valid(wr_valid), .wr_pc(wr_pc), .wr_dest(wr_dest), .wr_ret(wr_ret),
    .wr_kind(wr_kind), .wr_taken(wr_taken),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .init_done(init_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard the write port mid-cycle, then move 1 time unit past the edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (wr_valid) begin
      chk("wr_expected", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_entry", {wr_pc, wr_dest, wr_ret, wr_kind, wr_taken}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [31:0] pc, input logic [31:0] dest,
                      input logic [31:0] ret, input logic [4:0] kind, input logic tk);
    upd0_valid = v; upd0_pc = pc; upd0_dest = dest; upd0_ret = ret; upd0_kind = kind; upd0_taken = tk;
  endtask

  task automatic drv1(input logic v, input logic [31:0] pc, input logic [31:0] dest,
                      input logic [31:0] ret, input logic [4:0] kind, input logic tk);
    upd1_valid = v; upd1_pc = pc; upd1_dest = dest; upd1_ret = ret; upd1_kind = kind; upd1_taken = tk;
  endtask

  task automatic idle();
    drv0(1'b0, '0, '0, '0, '0, 1'b0);
    drv1(1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  // Clear sweep from index 0; optionally offer an update mid-sweep.
  task automatic sweep(input bit poke);
    for (int i = 0; i < (1 << IDX_BITS); i++) begin
      chk("clr_valid", clr_valid, 1'b1);
      chk("clr_idx", clr_idx, i);
      if (i == 0) begin
        chk("init_ready", upd_ready, 1'b0);
        chk("init_done_lo", init_done, 1'b0);
      end
      if (poke && i == 10) drv0(1'b1, 32'h7777, 32'h7700, '0, K_BR, 1'b1);
      if (poke && i == 11) idle();
      step();
    end
    chk("clr_valid_end", clr_valid, 1'b0);
    chk("init_done", init_done, 1'b1);
    chk("ready_after_init", upd_ready, 1'b1);
  endtask

  initial begin
    exp_t e;
    idle();
    step(); step();
    chk("rst_clr_valid", clr_valid, 1'b0);
    chk("rst_clr_idx", clr_idx, 0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_ready", upd_ready, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    resetn = 1'b1;
    step();
    sweep(1'b0);

    // Two pipes in one cycle drain in pipe order.
    drv0(1'b1, 32'h1000, 32'h1100, 32'h0, K_BR, 1'b1);
    drv1(1'b1, 32'h2000, 32'h3000, 32'h2008, K_JAL, 1'b0);
    step();
    q.push_back('{32'h1000, 32'h1100, 32'h0, K_BR, 1'b1});
    q.push_back('{32'h2000, 32'h3000, 32'h2008, K_JAL, 1'b0});
    idle();
    step(); step(); step();
    chk("drain2_empty", q.size(), 0);
    chk("drain2_ready", upd_ready, 1'b1);

    // kind=0 is ignored; the other pipe still allocates.
    drv0(1'b1, 32'hBAD, 32'hBAD0, '0, 5'b0, 1'b0);
    drv1(1'b1, 32'h4000, 32'h4400, '0, K_J, 1'b0);
    step();
    q.push_back('{32'h4000, 32'h4400, 32'h0, K_J, 1'b0});
    idle();
    step(); step();
    chk("kind0_empty", q.size(), 0);

    // Same-pc branch twice while the port is held busy.
    tbl_busy = 1'b1;
    drv0(1'b1, 32'h3000, 32'h3100, '0, K_BR, 1'b0);
    step();
    q.push_back('{32'h3000, 32'h3100, 32'h0, K_BR, 1'b0});
    drv0(1'b1, 32'h3000, 32'h3200, '0, K_BR, 1'b1);
    step();
`ifdef BPU_UPD_MERGE_EN
    e = q.pop_back();
    e.dest = 32'h3200; e.taken = 1'b1;
    q.push_back(e);
`else
    q.push_back('{32'h3000, 32'h3200, 32'h0, K_BR, 1'b1});
`endif
    idle();
    tbl_busy = 1'b0;
    step(); step(); step();
    chk("merge_empty", q.size(), 0);

    // Fill to DEPTH-1 under a busy port, then overflow one update.
    tbl_busy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drv0(1'b1, 32'h100 + 32'(8 * c), 32'h900 + 32'(c), 32'h0, K_J, 1'b0);
      drv1(c < 3, 32'h104 + 32'(8 * c), 32'hA00 + 32'(c), 32'h0, K_JAL, 1'b1);
      step();
      q.push_back('{32'h100 + 32'(8 * c), 32'h900 + 32'(c), 32'h0, K_J, 1'b0});
      if (c < 3) q.push_back('{32'h104 + 32'(8 * c), 32'hA00 + 32'(c), 32'h0, K_JAL, 1'b1});
      if (c == 2) chk("ready_at6", upd_ready, 1'b1);
    end
    idle();
    chk("ready_at7", upd_ready, 1'b0);
    chk("no_overflow_yet", overflow, 1'b0);
    chk("busy_stall", wr_valid, 1'b0);
    drv0(1'b1, 32'hDEAD, 32'hDEAD, '0, K_BR, 1'b1);
    step();
    idle();
    chk("overflow_set", overflow, 1'b1);
    step(); step();
    chk("stall_hold_ready", upd_ready, 1'b0);
    tbl_busy = 1'b0;
    repeat (8) step();
    chk("drain7_empty", q.size(), 0);
    chk("overflow_sticky", overflow, 1'b1);
    chk("ready_after_drain", upd_ready, 1'b1);

    // Reset mid-drain: leftover entries must never reach the table.
    tbl_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drv0(1'b1, 32'h500 + 32'(8 * c), 32'h50, 32'h0, K_J, 1'b0);
      drv1(c < 2, 32'h504 + 32'(8 * c), 32'h54, 32'h0, K_J, 1'b0);
      step();
      q.push_back('{32'h500 + 32'(8 * c), 32'h50, 32'h0, K_J, 1'b0});
      if (c < 2) q.push_back('{32'h504 + 32'(8 * c), 32'h54, 32'h0, K_J, 1'b0});
    end
    idle();
    tbl_busy = 1'b0;
    step();
    chk("pre_reset_left", q.size(), 4);
    resetn = 1'b0;
    tbl_busy = 1'b1;
    step();
    q.delete();
    tbl_busy = 1'b0;
    step();
    chk("mid_rst_wr_valid", wr_valid, 1'b0);
    chk("mid_rst_clr_idx", clr_idx, 0);
    chk("mid_rst_overflow", overflow, 1'b0);
    chk("mid_rst_init_done", init_done, 1'b0);
    resetn = 1'b1;
    step();
    sweep(1'b1);
    chk("init_drop_overflow", overflow, 1'b1);
    repeat (4) step();
    chk("no_stale_writes", q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
